// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures A, B and opcode one per debounced button press and holds them stable for the ALU.
// Optional input debouncer enabled by defining ALU_DEBOUNCE_EN.
module alu_operand_loader #(
  parameter int WIDTH           = 6,
  parameter int OP_WIDTH        = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [WIDTH-1:0]    SW,
  input  logic [OP_WIDTH-1:0] OP_SW,
  input  logic                BTN,
  input  logic                CLEAR,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [OP_WIDTH-1:0] ADD_SUB,
  output logic                OP_VALID,
  output logic                ISSUE,
  output logic [1:0]          STATE
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, EXEC} state_t;
  state_t state;
  logic sync1, sync2, level, prev, press;
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
    end
`ifdef ALU_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          deb;
  // level must differ from the debounced value for DEBOUNCE_CYCLES edges in a row
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync2 == deb)
      cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      deb <= sync2;
    end else
      cnt <= cnt + 1'b1;
  assign level = deb;
`else
  assign level = sync2;
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      prev  <= 1'b0;
      press <= 1'b0;
    end else begin
      prev  <= level;
      press <= level & ~prev;
    end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state    <= LOAD_A;
      A        <= '0;
      B        <= '0;
      ADD_SUB  <= '0;
      OP_VALID <= 1'b0;
      ISSUE    <= 1'b0;
    end else if (CLEAR) begin
      state    <= LOAD_A;
      A        <= '0;
      B        <= '0;
      ADD_SUB  <= '0;
      OP_VALID <= 1'b0;
      ISSUE    <= 1'b0;
    end else begin
      ISSUE <= 1'b0;
      if (press)
        case (state)
          LOAD_A: begin
            A     <= SW;
            state <= LOAD_B;
          end
          LOAD_B: begin
            B     <= SW;
            state <= LOAD_OP;
          end
          LOAD_OP: begin
            ADD_SUB  <= OP_SW;
            OP_VALID <= 1'b1;
            ISSUE    <= 1'b1;
            state    <= EXEC;
          end
          default: begin
            OP_VALID <= 1'b0;
            state    <= LOAD_A;
          end
        endcase
    end
  assign STATE = state;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of operand capture, clear, async reset and button timing.
module tb_alu_operand_loader;
`ifdef ALU_DEBOUNCE_EN
  localparam int DB  = 4;
  localparam int LAT = 3 + DB;
`else
  localparam int DB  = 4;
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 2;
  localparam int GAP  = LAT + 4;
  logic       CLK = 1'b0, RESET_N = 1'b0, BTN = 1'b0, CLEAR = 1'b0;
  logic [5:0] SW = '0;
  logic [2:0] OP_SW = '0;
  logic [5:0] A, B;
  logic [2:0] ADD_SUB;
  logic       OP_VALID, ISSUE;
  logic [1:0] STATE;
  int n_checks = 0, n_fail = 0, issue_cnt = 0, lat;
  alu_operand_loader #(.WIDTH(6), .OP_WIDTH(3), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SW(SW), .OP_SW(OP_SW), .BTN(BTN), .CLEAR(CLEAR),
    .A(A), .B(B), .ADD_SUB(ADD_SUB), .OP_VALID(OP_VALID), .ISSUE(ISSUE), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (ISSUE === 1'b1) issue_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press();
    BTN = 1'b1;
    repeat (HOLD) @(negedge CLK);
    BTN = 1'b0;
    repeat (GAP) @(negedge CLK);
  endtask
  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask
  initial begin
    do_reset();
    check("rst_state", STATE, 0);
    check("rst_a", A, 0);
    check("rst_b", B, 0);
    check("rst_op", ADD_SUB, 0);
    check("rst_valid", OP_VALID, 0);
    check("rst_issue", ISSUE, 0);
    // latency: state changes one edge after PRESS
    SW = 6'd5;
    BTN = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge CLK);
      if (STATE != 2'b00) lat = i;
    end
    check("press_latency", lat, LAT + 1);
    repeat (HOLD) @(negedge CLK);
    BTN = 1'b0;
    repeat (GAP) @(negedge CLK);
    check("t1_a_first", A, 5);
    check("t1_b_untouched", B, 0);
    SW = 6'd9;
    press();
    OP_SW = 3'b000;
    press();
    check("t1_a", A, 5);
    check("t1_b", B, 9);
    check("t1_op", ADD_SUB, 0);
    check("t1_state", STATE, 3);
    check("t1_valid", OP_VALID, 1);
    check("t1_issue_cnt", issue_cnt, 1);
    SW = 6'd63;
    press();
    check("t2_state", STATE, 0);
    check("t2_valid", OP_VALID, 0);
    check("t2_a_kept", A, 5);
    check("t2_b_kept", B, 9);
    check("t2_issue_cnt", issue_cnt, 1);
    press();
    check("t2_a_new", A, 63);
    check("t2_state_b", STATE, 1);
    do_reset();
    SW = 6'd17;
    BTN = 1'b1;
    repeat (100) @(negedge CLK);
    check("t3_held_state", STATE, 1);
    check("t3_held_a", A, 17);
    BTN = 1'b0;
    repeat (GAP) @(negedge CLK);
    check("t3_after_state", STATE, 1);
    SW = 6'd10;
    press();
    check("t4_pre_state", STATE, 2);
    OP_SW = 3'b001;
    BTN = 1'b1;
    repeat (LAT) @(negedge CLK);
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    check("t4_state", STATE, 0);
    check("t4_a", A, 0);
    check("t4_b", B, 0);
    check("t4_op", ADD_SUB, 0);
    check("t4_valid", OP_VALID, 0);
    BTN = 1'b0;
    repeat (GAP) @(negedge CLK);
    check("t4_state_after", STATE, 0);
    check("t4_issue_cnt", issue_cnt, 1);
    SW = 6'd12;
    press();
    check("t5_pre_a", A, 12);
    check("t5_pre_state", STATE, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("t5_async_a", A, 0);
    check("t5_async_state", STATE, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("t5_after_state", STATE, 0);
    check("t5_after_a", A, 0);
`ifdef ALU_DEBOUNCE_EN
    SW = 6'd33;
    BTN = 1'b1;
    repeat (2) @(negedge CLK);
    BTN = 1'b0;
    repeat (20) @(negedge CLK);
    check("t6_glitch_state", STATE, 0);
    check("t6_glitch_a", A, 0);
    press();
    check("t6_clean_state", STATE, 1);
    check("t6_clean_a", A, 33);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
